// File: rtl/rgb_pwm_mixer.sv
// Multi-channel PWM generator for the RGB LED pins: shared prescaled period counter,
// double-buffered duties applied only at the period wrap, optional per-channel phase stagger.
module rgb_pwm_mixer #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter bit          STAGGER  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_load,
    output logic                      update_pend,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam int unsigned PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned OFFSET = (1 << WIDTH) / CHANNELS;

    logic [PW-1:0]             pcnt;
    logic [WIDTH-1:0]          cnt;
    logic [CHANNELS*WIDTH-1:0] pending;
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic [CHANNELS-1:0]       pwm_next;
    logic                      tick;
    logic                      wrap;

    always_comb begin
        tick = (pcnt == PW'(PRESCALE - 1));
        wrap = tick && (cnt == '1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] PHASE = STAGGER ? WIDTH'(i * OFFSET) : '0;
        logic [WIDTH-1:0] duty;
        logic [WIDTH-1:0] ph;

        always_comb begin
            duty        = shadow[i*WIDTH +: WIDTH];
            ph          = cnt + PHASE;
            // Full-scale duty is forced high so no low step appears at the wrap.
            pwm_next[i] = (duty == '1) || (ph < duty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt         <= '0;
            cnt          <= '0;
            pending      <= '0;
            shadow       <= '0;
            update_pend  <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            pcnt         <= tick ? '0 : pcnt + 1'b1;
            period_start <= wrap;
            pwm_out      <= pwm_next;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            if (wrap && update_pend) begin
                shadow <= pending;
            end
            // A load coinciding with the wrap keeps the flag set for the freshly captured value.
            if (duty_load) begin
                pending     <= duty_in;
                update_pend <= 1'b1;
            end else if (wrap) begin
                update_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_mixer.sv
// Directed bench for rgb_pwm_mixer: a default instance (3ch, 8b, no prescale, no stagger)
// and a staggered instance with PRESCALE=4; duty vectors table-driven, corner cases hand-written.
module tb_rgb_pwm_mixer;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [23:0] duty_in0, duty_in1;
    logic        load0, load1;
    logic        pend0, pend1;
    logic        ps0, ps1;
    logic [2:0]  pwm0, pwm1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    rgb_pwm_mixer #(.CHANNELS(3), .WIDTH(8), .PRESCALE(1), .STAGGER(1'b0)) u0 (
        .clk(clk), .rst(rst0), .duty_in(duty_in0), .duty_load(load0),
        .update_pend(pend0), .period_start(ps0), .pwm_out(pwm0)
    );

    rgb_pwm_mixer #(.CHANNELS(3), .WIDTH(8), .PRESCALE(4), .STAGGER(1'b1)) u1 (
        .clk(clk), .rst(rst1), .duty_in(duty_in1), .duty_load(load1),
        .update_pend(pend1), .period_start(ps1), .pwm_out(pwm1)
    );

    typedef struct {
        logic [7:0]  r, g, b;
        int unsigned er, eg, eb;
    } vec_t;

    vec_t vecs[5];

    task automatic step(input int unsigned n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ps0(input int unsigned limit, output int unsigned n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ps0 && n <= limit);
    endtask

    task automatic wait_ps1(input int unsigned limit, output int unsigned n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ps1 && n <= limit);
    endtask

    // One 256-clk period of u0 starting at a wrap; counts high cycles per channel.
    task automatic measure0(output int unsigned cr, output int unsigned cg, output int unsigned cb,
                            output logic pend_last, output logic ps_end);
        cr = 0; cg = 0; cb = 0; pend_last = 1'b0;
        for (int unsigned k = 1; k <= 256; k++) begin
            step();
            cr += pwm0[0]; cg += pwm0[1]; cb += pwm0[2];
            if (k == 255) pend_last = pend0;
        end
        ps_end = ps0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n, cr, cg, cb;
        logic        pl, pe, drop;
        int unsigned cnt1[3];
        int unsigned rise[3];
        logic [2:0]  prev;

        vecs[0] = '{r: 8'd64,  g: 8'd128, b: 8'd0,   er: 64,  eg: 128, eb: 0};
        vecs[1] = '{r: 8'd255, g: 8'd255, b: 8'd255, er: 256, eg: 256, eb: 256};
        vecs[2] = '{r: 8'd1,   g: 8'd254, b: 8'd17,  er: 1,   eg: 254, eb: 17};
        vecs[3] = '{r: 8'd0,   g: 8'd255, b: 8'd128, er: 0,   eg: 256, eb: 128};
        vecs[4] = '{r: 8'd192, g: 8'd192, b: 8'd192, er: 192, eg: 192, eb: 192};

        rst0 = 1'b1; rst1 = 1'b1;
        load0 = 1'b0; load1 = 1'b0;
        duty_in0 = '0; duty_in1 = '0;

        step(10);
        check("reset pwm_out", pwm0, 0);
        check("reset period_start", ps0, 0);
        check("reset update_pend", pend0, 0);

        rst0 = 1'b0;
        wait_ps0(300, n);
        check("first period_start delay", n, 256);

        // Each vector: load at a wrap, let the next wrap apply it, then measure a full period.
        for (int unsigned v = 0; v < 5; v++) begin
            duty_in0 = {vecs[v].b, vecs[v].g, vecs[v].r};
            load0 = 1'b1;
            step();
            load0 = 1'b0;
            check($sformatf("v%0d pend after load", v), pend0, 1);
            step(254);
            check($sformatf("v%0d pend before wrap", v), pend0, 1);
            step();
            check($sformatf("v%0d period_start", v), ps0, 1);
            measure0(cr, cg, cb, pl, pe);
            check($sformatf("v%0d high R", v), cr, vecs[v].er);
            check($sformatf("v%0d high G", v), cg, vecs[v].eg);
            check($sformatf("v%0d high B", v), cb, vecs[v].eb);
            check($sformatf("v%0d pend cleared", v), pend0, 0);
            check($sformatf("v%0d period end", v), pe, 1);
        end

        // Mid-period load of 32 at cnt=100 over an active 192.
        cr = 0; drop = 1'b0;
        for (int unsigned k = 1; k <= 256; k++) begin
            step();
            cr += pwm0[0];
            if (k == 100) begin
                duty_in0 = {3{8'd32}};
                load0 = 1'b1;
            end
            if (k == 101) begin
                load0 = 1'b0;
                check("midload pend set", pend0, 1);
            end
            if (k > 101 && k < 256 && !pend0) drop = 1'b1;
        end
        check("midload current period R", cr, 192);
        check("midload pend held", drop, 0);
        check("midload pend cleared at wrap", pend0, 0);
        check("midload wrap", ps0, 1);
        measure0(cr, cg, cb, pl, pe);
        check("midload next period R", cr, 32);
        check("midload next period G", cg, 32);

        // Load on the wrap cycle: pending 100 applies now, 200 one period later.
        duty_in0 = {3{8'd100}};
        load0 = 1'b1;
        step();
        load0 = 1'b0;
        step(254);
        duty_in0 = {3{8'd200}};
        load0 = 1'b1;
        step();
        load0 = 1'b0;
        check("wrapload period_start", ps0, 1);
        check("wrapload pend stays", pend0, 1);
        measure0(cr, cg, cb, pl, pe);
        check("wrapload first period R", cr, 100);
        check("wrapload pend before 2nd wrap", pl, 1);
        check("wrapload 2nd wrap", pe, 1);
        check("wrapload pend cleared", pend0, 0);
        measure0(cr, cg, cb, pl, pe);
        check("wrapload second period R", cr, 200);
        check("wrapload second period B", cb, 200);

        // Staggered, prescaled instance.
        check("u1 reset pwm_out", pwm1, 0);
        rst1 = 1'b0;
        wait_ps1(1100, n);
        check("u1 first period_start delay", n, 1024);
        duty_in1 = {3{8'd85}};
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        step(1023);
        check("u1 wrap after 1024", ps1, 1);
        prev = pwm1;
        for (int unsigned c = 0; c < 3; c++) begin
            cnt1[c] = 0;
            rise[c] = 0;
        end
        for (int unsigned k = 1; k <= 1024; k++) begin
            step();
            for (int unsigned c = 0; c < 3; c++) begin
                cnt1[c] += pwm1[c];
                if (pwm1[c] && !prev[c] && rise[c] == 0) rise[c] = k;
            end
            prev = pwm1;
        end
        check("u1 high R", cnt1[0], 340);
        check("u1 high G", cnt1[1], 340);
        check("u1 high B", cnt1[2], 340);
        // ph_i = cnt + i*85 < 85: R high for cnt 0..84, B for 86..170, G for 171..255;
        // sample k reflects cnt = (k-1)/4.
        check("u1 rise R", rise[0], 1);
        check("u1 rise B", rise[2], 345);
        check("u1 rise G", rise[1], 685);

        step(100);
        check("u1 R high mid-period", pwm1[0], 1);
        rst1 = 1'b1;
        step();
        check("u1 mid reset pwm_out", pwm1, 0);
        check("u1 mid reset period_start", ps1, 0);
        check("u1 mid reset pend", pend1, 0);
        rst1 = 1'b0;
        step(2);
        check("u1 after reset pwm_out", pwm1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
